// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm melody sequencer.
//   state_t : sequencer FSM encoding
//   note_t  : one note-table entry {freq (Hz, 0 = rest), beats (1..4 encoded 0..3)}
//   NOTE_*  : equal-tempered note frequencies in Hz, C4 through C6
package alarm_pkg;

  localparam int unsigned FREQ_W  = 23;
  localparam int unsigned BEATS_W = 2;
  localparam int unsigned IDX_W   = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_NOTE   = 2'd1,
    ST_GAP    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  typedef struct packed {
    logic [FREQ_W-1:0]  freq;
    logic [BEATS_W-1:0] beats;
  } note_t;

  localparam logic [FREQ_W-1:0] NOTE_REST = 23'd0;
  localparam logic [FREQ_W-1:0] NOTE_C4   = 23'd262;
  localparam logic [FREQ_W-1:0] NOTE_D4   = 23'd294;
  localparam logic [FREQ_W-1:0] NOTE_E4   = 23'd330;
  localparam logic [FREQ_W-1:0] NOTE_F4   = 23'd349;
  localparam logic [FREQ_W-1:0] NOTE_G4   = 23'd392;
  localparam logic [FREQ_W-1:0] NOTE_A4   = 23'd440;
  localparam logic [FREQ_W-1:0] NOTE_B4   = 23'd494;
  localparam logic [FREQ_W-1:0] NOTE_C5   = 23'd523;
  localparam logic [FREQ_W-1:0] NOTE_D5   = 23'd587;
  localparam logic [FREQ_W-1:0] NOTE_E5   = 23'd659;
  localparam logic [FREQ_W-1:0] NOTE_F5   = 23'd698;
  localparam logic [FREQ_W-1:0] NOTE_G5   = 23'd784;
  localparam logic [FREQ_W-1:0] NOTE_A5   = 23'd880;
  localparam logic [FREQ_W-1:0] NOTE_B5   = 23'd988;
  localparam logic [FREQ_W-1:0] NOTE_C6   = 23'd1047;

  // Builds a table entry from a frequency and a beat count of 1..4.
  function automatic note_t mk_note(input logic [FREQ_W-1:0] freq, input int unsigned beats);
    note_t n;
    n.freq  = freq;
    n.beats = BEATS_W'(beats - 1);
    return n;
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Combinational note table for the alarm melody.
//   idx   : note index (0..63)
//   entry : {freq, beats} for that index; unused indices read as a one-beat rest
// The first four entries double as the short test phrase {A4,1}{rest,1}{C5,2}{E5,4},
// so a SONG_LEN of 4 plays just that phrase.
module melody_rom
  import alarm_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output note_t            entry
);

  always_comb begin
    entry = mk_note(NOTE_REST, 1);
    unique case (idx)
      6'd0:    entry = mk_note(NOTE_A4,   1);
      6'd1:    entry = mk_note(NOTE_REST, 1);
      6'd2:    entry = mk_note(NOTE_C5,   2);
      6'd3:    entry = mk_note(NOTE_E5,   4);
      6'd4:    entry = mk_note(NOTE_G5,   1);
      6'd5:    entry = mk_note(NOTE_E5,   1);
      6'd6:    entry = mk_note(NOTE_C5,   2);
      6'd7:    entry = mk_note(NOTE_REST, 2);
      6'd8:    entry = mk_note(NOTE_G4,   1);
      6'd9:    entry = mk_note(NOTE_C5,   1);
      6'd10:   entry = mk_note(NOTE_E5,   1);
      6'd11:   entry = mk_note(NOTE_G5,   1);
      6'd12:   entry = mk_note(NOTE_C6,   2);
      6'd13:   entry = mk_note(NOTE_G5,   1);
      6'd14:   entry = mk_note(NOTE_C6,   4);
      6'd15:   entry = mk_note(NOTE_REST, 2);
      default: entry = mk_note(NOTE_REST, 1);
    endcase
  end

endmodule

// File: rtl/alarm_melody_seq.sv
// Alarm melody sequencer: walks the note table and drives the tone generator.
//   clk, reset_n : system clock, async active-low reset
//   start, stop  : one-cycle play / abort requests (stop wins)
//   rate         : tone frequency in Hz for the tone generator, never 0
//   toneEnable   : gates the tone generator
//   busy         : melody in progress
//   done         : one-cycle pulse when a non-looping melody completes
//   noteIdx      : current note index
// Every note occupies exactly beats*BEAT_CYCLES cycles: a sounding part followed by
// GAP_CYCLES of silence, so the gap never stretches the tempo.
module alarm_melody_seq
  import alarm_pkg::*;
#(
  parameter int unsigned BEAT_CYCLES = 1250000,
  parameter int unsigned GAP_CYCLES  = 250000,
  parameter int unsigned SONG_LEN    = 16,
  parameter int unsigned LOOP        = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  output logic [FREQ_W-1:0] rate,
  output logic              toneEnable,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  noteIdx
);

  localparam int unsigned CNT_W = $clog2(4 * BEAT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FREQ_W-1:0]  rate_q, rate_d;
  logic               tone_q, tone_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [IDX_W-1:0]   rom_idx;
  note_t              rom_entry;
  logic [CNT_W-1:0]   note_load;
  logic [CNT_W-1:0]   gap_load;
  logic               entry_rest;
  logic               load_note;

  // ROM is addressed with the index of the note about to start, so the new
  // frequency and duration are ready on the edge that enters NOTE.
  always_comb begin
    rom_idx = idx_q;
    unique case (state_q)
      ST_IDLE: rom_idx = '0;
      ST_GAP:  rom_idx = (idx_q < LAST_IDX) ? idx_q + IDX_W'(1) : '0;
      default: rom_idx = idx_q;
    endcase
  end

  melody_rom u_rom (
    .idx   (rom_idx),
    .entry (rom_entry)
  );

  // Segment lengths minus one, since the counter runs down to 0 inclusive.
  assign note_load  = CNT_W'((32'(rom_entry.beats) + 32'd1) * BEAT_CYCLES - GAP_CYCLES - 32'd1);
  assign gap_load   = CNT_W'(GAP_CYCLES - 32'd1);
  assign entry_rest = (rom_entry.freq == NOTE_REST);

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rate_d    = rate_q;
    tone_d    = tone_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    load_note = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d     = '0;
          load_note = 1'b1;
        end
      end
      ST_NOTE: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = gap_load;
          tone_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (idx_q < LAST_IDX) begin
          idx_d     = idx_q + IDX_W'(1);
          load_note = 1'b1;
        end else if (LOOP != 0) begin
          idx_d     = '0;
          load_note = 1'b1;
        end else begin
          state_d = ST_FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        rate_d  = FREQ_W'(1);
        tone_d  = 1'b0;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Entering a note is the only place rate may change while playing.
    if (load_note) begin
      state_d = ST_NOTE;
      cnt_d   = note_load;
      rate_d  = entry_rest ? FREQ_W'(1) : rom_entry.freq;
      tone_d  = !entry_rest;
      busy_d  = 1'b1;
    end

    // Abort overrides everything, including a simultaneous start.
    if (stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      rate_d  = FREQ_W'(1);
      tone_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rate_q  <= FREQ_W'(1);
      tone_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rate_q  <= rate_d;
      tone_q  <= tone_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rate       = rate_q;
  assign toneEnable = tone_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign noteIdx    = idx_q;

endmodule

// File: tb/tb_alarm_melody_seq.sv
// Bench for alarm_melody_seq: three instances sharing stimulus
//   A: LOOP=0, GAP=2   B: LOOP=1, GAP=2   C: LOOP=0, GAP=7
// all with BEAT_CYCLES=8 and the 4-entry phrase {440,1}{rest,1}{523,2}{659,4}.
module tb_alarm_melody_seq;

  localparam int B_CYC = 8;
  localparam int NOTES = 4;
  localparam int T_LEN = 64;

  typedef struct packed {
    int   rate;
    logic en;
    logic busy;
    logic done;
    int   idx;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n, start, stop;

  logic [22:0] rate_a, rate_b, rate_c;
  logic        en_a, en_b, en_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic [5:0]  idx_a, idx_b, idx_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alarm_melody_seq #(.BEAT_CYCLES(8), .GAP_CYCLES(2), .SONG_LEN(4), .LOOP(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .rate(rate_a), .toneEnable(en_a), .busy(busy_a), .done(done_a), .noteIdx(idx_a));

  alarm_melody_seq #(.BEAT_CYCLES(8), .GAP_CYCLES(2), .SONG_LEN(4), .LOOP(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .rate(rate_b), .toneEnable(en_b), .busy(busy_b), .done(done_b), .noteIdx(idx_b));

  alarm_melody_seq #(.BEAT_CYCLES(8), .GAP_CYCLES(7), .SONG_LEN(4), .LOOP(0)) dut_c (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .rate(rate_c), .toneEnable(en_c), .busy(busy_c), .done(done_c), .noteIdx(idx_c));

  function automatic int freq_of(input int n);
    case (n)
      0: return 440;
      1: return 0;
      2: return 523;
      default: return 659;
    endcase
  endfunction

  function automatic int beats_of(input int n);
    case (n)
      0: return 1;
      1: return 1;
      2: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit loop_of(input int i);
    return (i == 1);
  endfunction

  function automatic int gap_of(input int i);
    return (i == 2) ? 7 : 2;
  endfunction

  // Expected outputs k cycles after the start edge (k=1 is the first playing cycle).
  function automatic exp_t model_at(input bit act, input int k, input bit loop, input int g);
    exp_t e;
    int   p;
    int   len;
    e.rate = 1; e.en = 1'b0; e.busy = 1'b0; e.done = 1'b0; e.idx = 0;
    if (!act || k < 1 || (!loop && k > T_LEN + 1)) return e;
    if (!loop && k == T_LEN + 1) begin
      e.done = 1'b1;
      e.rate = freq_of(NOTES - 1);
      e.idx  = NOTES - 1;
      return e;
    end
    p = (k - 1) % T_LEN;
    for (int n = 0; n < NOTES; n++) begin
      len = beats_of(n) * B_CYC;
      if (p < len) begin
        e.busy = 1'b1;
        e.idx  = n;
        e.rate = (freq_of(n) == 0) ? 1 : freq_of(n);
        e.en   = (freq_of(n) != 0) && (p < len - g);
        return e;
      end
      p = p - len;
    end
    return e;
  endfunction

  function automatic bit accepts_start(input bit act, input int k, input bit loop);
    return !act || (!loop && k > T_LEN + 1);
  endfunction

  // Model bookkeeping: cycle count and per-instance start cycle.
  int cyc;
  int t0 [3];
  bit act [3];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc <= 0;
      for (int i = 0; i < 3; i++) begin
        act[i] <= 1'b0;
        t0[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (stop) begin
          act[i] <= 1'b0;
        end else if (start && accepts_start(act[i], cyc - t0[i], loop_of(i))) begin
          act[i] <= 1'b1;
          t0[i]  <= cyc;
        end
      end
      cyc <= cyc + 1;
    end
  end

  task automatic chk(input string name, input int act_v, input int exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act_v, exp_v, $time);
    end
  endtask

  task automatic cmp_dut(input string tag, input exp_t e, input int r, input logic en,
                         input logic bz, input logic dn, input int ix);
    chk({tag, "_rate"}, r, e.rate);
    chk({tag, "_en"},   int'(en), int'(e.en));
    chk({tag, "_busy"}, int'(bz), int'(e.busy));
    chk({tag, "_done"}, int'(dn), int'(e.done));
    chk({tag, "_idx"},  ix, e.idx);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      cmp_dut("mdl_a", model_at(act[0], cyc - t0[0], loop_of(0), gap_of(0)),
              int'(rate_a), en_a, busy_a, done_a, int'(idx_a));
      cmp_dut("mdl_b", model_at(act[1], cyc - t0[1], loop_of(1), gap_of(1)),
              int'(rate_b), en_b, busy_b, done_b, int'(idx_b));
      cmp_dut("mdl_c", model_at(act[2], cyc - t0[2], loop_of(2), gap_of(2)),
              int'(rate_c), en_c, busy_c, done_c, int'(idx_c));
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives start/stop for exactly one active edge; called and returns on a negedge.
  task automatic pulse(input logic s, input logic p);
    start = s;
    stop  = p;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    wait_cyc(3);
    chk("rst_rate", int'(rate_a), 1);
    chk("rst_en",   int'(en_a),   0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_idx",  int'(idx_a),  0);
    reset_n = 1'b1;
    wait_cyc(2);

    // Full melody; hand-computed points along the timeline.
    pulse(1'b1, 1'b0);                               // k=1
    chk("k1_a_rate", int'(rate_a), 440);
    chk("k1_a_en",   int'(en_a), 1);
    chk("k1_a_busy", int'(busy_a), 1);
    chk("k1_c_en",   int'(en_c), 1);
    wait_cyc(1);                                     // k=2
    chk("k2_c_en",   int'(en_c), 0);
    chk("k2_c_rate", int'(rate_c), 440);
    chk("k2_c_busy", int'(busy_c), 1);
    wait_cyc(4);                                     // k=6
    chk("k6_a_en",   int'(en_a), 1);
    wait_cyc(1);                                     // k=7
    chk("k7_a_en",   int'(en_a), 0);
    chk("k7_a_rate", int'(rate_a), 440);
    wait_cyc(2);                                     // k=9
    chk("k9_a_rate", int'(rate_a), 1);
    chk("k9_a_en",   int'(en_a), 0);
    chk("k9_a_idx",  int'(idx_a), 1);
    wait_cyc(8);                                     // k=17
    chk("k17_a_rate", int'(rate_a), 523);
    chk("k17_a_idx",  int'(idx_a), 2);
    chk("k17_c_en",   int'(en_c), 1);
    wait_cyc(9);                                     // k=26
    chk("k26_c_en",   int'(en_c), 0);
    chk("k26_c_rate", int'(rate_c), 523);
    wait_cyc(5);                                     // k=31
    chk("k31_a_en",   int'(en_a), 0);
    chk("k31_a_rate", int'(rate_a), 523);
    wait_cyc(2);                                     // k=33
    chk("k33_a_rate", int'(rate_a), 659);
    chk("k33_a_idx",  int'(idx_a), 3);
    wait_cyc(31);                                    // k=64
    chk("k64_a_busy", int'(busy_a), 1);
    chk("k64_a_done", int'(done_a), 0);
    chk("k64_b_idx",  int'(idx_b), 3);
    wait_cyc(1);                                     // k=65
    chk("k65_a_done", int'(done_a), 1);
    chk("k65_a_busy", int'(busy_a), 0);
    chk("k65_c_done", int'(done_c), 1);
    chk("k65_b_idx",  int'(idx_b), 0);
    chk("k65_b_rate", int'(rate_b), 440);
    chk("k65_b_en",   int'(en_b), 1);
    chk("k65_b_done", int'(done_b), 0);
    wait_cyc(1);                                     // k=66
    chk("k66_a_done", int'(done_a), 0);
    chk("k66_a_rate", int'(rate_a), 1);
    chk("k66_a_idx",  int'(idx_a), 0);

    // Stop during note 2 (B is still looping and ignores this start).
    pulse(1'b1, 1'b0);                               // A,C k=1
    wait_cyc(19);                                    // k=20
    chk("stop_pre_a_idx", int'(idx_a), 2);
    pulse(1'b0, 1'b1);
    chk("stop_a_en",   int'(en_a), 0);
    chk("stop_a_busy", int'(busy_a), 0);
    chk("stop_a_idx",  int'(idx_a), 0);
    chk("stop_a_done", int'(done_a), 0);
    chk("stop_a_rate", int'(rate_a), 1);
    chk("stop_b_busy", int'(busy_b), 0);
    wait_cyc(3);

    // Start re-pulsed mid-melody must not restart it.
    pulse(1'b1, 1'b0);                               // k=1
    wait_cyc(9);                                     // k=10
    pulse(1'b1, 1'b0);                               // k=11
    chk("restart_a_idx",  int'(idx_a), 1);
    wait_cyc(6);                                     // k=17
    chk("restart_a_rate", int'(rate_a), 523);
    chk("restart_a_idx2", int'(idx_a), 2);
    wait_cyc(50);                                    // k=67
    pulse(1'b0, 1'b1);

    // start and stop together in IDLE.
    pulse(1'b1, 1'b1);
    chk("both_a_busy", int'(busy_a), 0);
    chk("both_b_busy", int'(busy_b), 0);
    chk("both_b_en",   int'(en_b), 0);
    wait_cyc(4);
    chk("both_b_idle", int'(busy_b), 0);

    // Asynchronous reset in the middle of a note.
    pulse(1'b1, 1'b0);                               // k=1
    wait_cyc(2);                                     // k=3
    chk("prerst_a_en", int'(en_a), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_a_en",   int'(en_a), 0);
    chk("arst_a_rate", int'(rate_a), 1);
    chk("arst_a_busy", int'(busy_a), 0);
    chk("arst_b_busy", int'(busy_b), 0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_cyc(10);
    chk("post_rst_a_busy", int'(busy_a), 0);
    chk("post_rst_a_en",   int'(en_a), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
